// File: rtl/microwave_ctrl.sv
// Microwave cooking sequencer: button/door conditioning, 1 s tick generation and the IDLE/COOK/PAUSE/DONE FSM.
// Optional buzzer output and its counter are built only when MW_BEEP_EN is defined.
module microwave_ctrl #(
    parameter int TICK_DIV    = 100,
    parameter int DONE_CYCLES = 300,
    parameter int BEEP_CYCLES = 50
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic       timer_loadn,
    output logic       timer_clear,
    output logic       timer_enable,
    output logic       mag_on,
    output logic       done,
`ifdef MW_BEEP_EN
    output logic       beep,
`endif
    output logic [1:0] state
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DONE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, next_state;
    logic [2:0]    start_s, stop_s, door_s;
    logic          start_p, stop_p;
    logic          door_q;
    logic [TW-1:0] tick_cnt;
    logic [DW-1:0] dwell_cnt;
    logic          dwell_last, enter_done;

    // door takes one extra stage so it is acted on with the same latency as a button press
    assign door_q     = door_s[2];
    assign dwell_last = (dwell_cnt == DWELL_LAST);
    assign enter_done = (next_state == DONE) && (state_q != DONE);
    assign state      = state_q;

    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:  if (start_p && door_q && !timer_zero) next_state = COOK;
            COOK: begin
                if (timer_zero)              next_state = DONE;
                else if (!door_q || stop_p)  next_state = PAUSE;
            end
            PAUSE: begin
                if (stop_p)                  next_state = IDLE;
                else if (start_p && door_q)  next_state = COOK;
            end
            DONE:  if (stop_p || !door_q || dwell_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            start_s      <= 3'b111;
            stop_s       <= 3'b111;
            door_s       <= 3'b000;
            start_p      <= 1'b0;
            stop_p       <= 1'b0;
            state_q      <= IDLE;
            tick_cnt     <= '0;
            dwell_cnt    <= '0;
            timer_loadn  <= 1'b0;
            timer_clear  <= 1'b0;
            timer_enable <= 1'b0;
            mag_on       <= 1'b0;
            done         <= 1'b0;
        end else begin
            // [0],[1] form the synchronizer, [2] is the previous synchronized level
            start_s <= {start_s[1:0], startn};
            stop_s  <= {stop_s[1:0], stopn};
            door_s  <= {door_s[1:0], door_closed};
            start_p <= start_s[2] & ~start_s[1];
            stop_p  <= stop_s[2] & ~stop_s[1];

            state_q <= next_state;

            // partial second survives PAUSE; any return to IDLE or DONE restarts it
            if (next_state == IDLE || next_state == DONE)
                tick_cnt <= '0;
            else if (state_q == COOK)
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;

            if (state_q == DONE && next_state == DONE)
                dwell_cnt <= dwell_cnt + 1'b1;
            else
                dwell_cnt <= '0;

            timer_loadn  <= (next_state != IDLE);
            mag_on       <= (next_state == COOK);
            timer_clear  <= stop_p && (state_q == IDLE || state_q == PAUSE);
            // no count pulse when leaving COOK on this edge
            timer_enable <= (state_q == COOK) && (next_state == COOK) && (tick_cnt == TICK_LAST);
            done         <= enter_done;
        end
    end

`ifdef MW_BEEP_EN
    localparam int BW = $clog2(BEEP_CYCLES + 1);
    logic [BW-1:0] beep_cnt;

    always_ff @(posedge clock) begin
        if (!resetn)
            beep_cnt <= '0;
        else if (stop_p)
            beep_cnt <= '0;
        else if (enter_done)
            beep_cnt <= BW'(BEEP_CYCLES);
        else if (beep_cnt != '0)
            beep_cnt <= beep_cnt - 1'b1;
    end

    assign beep = (beep_cnt != '0);
`else
    // keeps the buzzer length referenced in builds without the buzzer
    localparam int beep_cycles_unused = BEEP_CYCLES;
`endif

endmodule
